pulse_generator: RTL and testbench
==================================

PULSE_GENERATOR -- requirements
Module: pulse_generator

Interface
REQ-001 Parameter RESET_DELAY, default 8: clock cycles from reset release to ready; legal 1..255.
REQ-002 Parameter START_DELAY, default 4: clock cycles from start rising to pulse_out rising; legal 1..255.
REQ-003 Parameter PULSE_WIDTH, default 6: clock cycles pulse_out stays high; legal 1..255.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  pulse request; acted on at its rising edge (sampled 0 then 1).
REQ-007 pulse_out  output  1  generated pulse, registered.
REQ-008 pulse_out_s  output  1  pulse_out delayed by exactly one clock, registered.
REQ-009 pulse_out_duplicate  output  1  independent register carrying the same value as pulse_out (see Configuration).
REQ-010 pulse_generator_ready_after_reset  output  1  high once the post-reset delay has elapsed; stays high until next reset.

Function
REQ-011 FSM states SHALL be: WAIT_READY, IDLE, DELAY, PULSE.
REQ-012 Internal down/up counter SHALL be named counter, width 8 bits, shared by all timed states.
REQ-013 WAIT_READY: counter counts clocks; ready SHALL rise exactly RESET_DELAY clocks after the edge at which reset was last sampled high; then IDLE.
REQ-014 IDLE: on detected rising edge of start -> DELAY; start held high for several cycles SHALL count as one request.
REQ-015 DELAY: pulse_out SHALL rise exactly START_DELAY clocks after the edge at which start was first sampled high; then PULSE.
REQ-016 PULSE: pulse_out high for exactly PULSE_WIDTH clocks, then low and FSM -> IDLE.
REQ-017 Start rising edges in WAIT_READY, DELAY or PULSE SHALL be ignored (not queued).
REQ-018 A new start rising edge in the first IDLE cycle after a pulse SHALL be accepted.
REQ-019 Start edge detector register SHALL be cleared by reset so start already high at reset release is not a request.
REQ-020 pulse_out_s SHALL equal pulse_out of the previous cycle in all states.

Reset
REQ-021 While reset is sampled high: FSM=WAIT_READY, counter=0, pulse_out=0, pulse_out_s=0, pulse_out_duplicate=0, ready=0.
REQ-022 Reset asserted mid-DELAY or mid-PULSE SHALL abort at that edge; pulse_out low next cycle; full RESET_DELAY wait repeats.

Configuration
REQ-023 Macro PULSE_GENERATOR_DUPLICATE_EN defined: pulse_out_duplicate is a separate flop, preserved in synthesis, always equal to pulse_out.
REQ-024 Macro undefined: pulse_out_duplicate SHALL be tied to 0 and no flop instantiated.

Verification (Tclk=10 ns, defaults)
REQ-025 Reset high 100 ns, released on clock edge -> ready rises exactly 80 ns later.
REQ-026 Start high 20 ns once ready -> pulse_out rises 40 ns after start rise, high 60 ns, pulse_out_s same shape 10 ns later.
REQ-027 Second start during DELAY and during PULSE -> single 60 ns pulse, no extra pulse afterwards.
REQ-028 Reset asserted 2 cycles into PULSE -> pulse_out, ready low next cycle; ready returns 80 ns after release; next start gives normal pulse.
REQ-029 Start held high across reset release -> no pulse until start falls and rises again.
REQ-030 Build with and without PULSE_GENERATOR_DUPLICATE_EN -> duplicate equals pulse_out every cycle, or is constant 0.

Source files
------------

// File: rtl/pulse_generator.sv
// pulse_generator: after reset waits RESET_DELAY clocks, then turns each rising
// edge of start into a pulse that rises START_DELAY clocks after the request and
// stays high for PULSE_WIDTH clocks. pulse_out_s is pulse_out delayed one clock.
// Optional feature macro: PULSE_GENERATOR_DUPLICATE_EN adds a separate, preserved
// flop that mirrors pulse_out on pulse_out_duplicate; without it that port is 0.

// Runtime checks on the generator's externally visible behaviour.
module pulse_generator_checker (
    input logic clk,
    input logic reset,
    input logic pulse_out,
    input logic pulse_out_s,
    input logic pulse_out_duplicate,
    input logic ready
);

    // A pulse can only exist once the post-reset wait has completed.
    a_pulse_needs_ready : assert property (@(posedge clk) pulse_out |-> ready);

    // Outside reset the delayed copy follows pulse_out one clock later.
    a_delayed_copy : assert property (@(posedge clk)
        !reset |=> (pulse_out_s == $past(pulse_out)));

`ifdef PULSE_GENERATOR_DUPLICATE_EN
    // The duplicate register always carries the same value as pulse_out.
    a_duplicate_equal : assert property (@(posedge clk)
        pulse_out_duplicate == pulse_out);
`else
    // Without the duplicate feature the port is a constant zero.
    a_duplicate_zero : assert property (@(posedge clk)
        pulse_out_duplicate == 1'b0);
`endif

endmodule

module pulse_generator #(
    parameter int unsigned RESET_DELAY = 8,
    parameter int unsigned START_DELAY = 4,
    parameter int unsigned PULSE_WIDTH = 6
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic pulse_out,
    output logic pulse_out_s,
    output logic pulse_out_duplicate,
    output logic pulse_generator_ready_after_reset
);

    typedef enum logic [1:0] {
        WAIT_READY = 2'b00,
        IDLE       = 2'b01,
        DELAY      = 2'b10,
        PULSE      = 2'b11
    } state_t;

    // Terminal counts: a timed state of length N leaves when counter reaches N-1,
    // because the counter starts at zero on the edge that enters the state.
    localparam logic [7:0] RESET_LAST = 8'(RESET_DELAY - 1);
    localparam logic [7:0] START_LAST = 8'(START_DELAY - 1);
    localparam logic [7:0] WIDTH_LAST = 8'(PULSE_WIDTH - 1);

    state_t     state_r;
    state_t     next_state_s;
    logic [7:0] counter;
    logic [7:0] counter_next_s;
    logic       start_d_r;
    logic       start_rise_s;
    logic       pulse_r;
    logic       pulse_next_s;
    logic       pulse_s_r;
    logic       ready_r;
    logic       ready_next_s;

    // A request is start sampled high after being sampled low; holding it high
    // therefore produces exactly one request.
    assign start_rise_s = start & ~start_d_r;

    // Next-state, shared-counter and output decisions for the sequencer.
    always_comb begin
        next_state_s   = state_r;
        counter_next_s = counter;
        pulse_next_s   = pulse_r;
        ready_next_s   = ready_r;
        case (state_r)
            WAIT_READY: begin
                pulse_next_s = 1'b0;
                if (counter == RESET_LAST) begin
                    next_state_s   = IDLE;
                    counter_next_s = 8'd0;
                    ready_next_s   = 1'b1;
                end else begin
                    counter_next_s = counter + 8'd1;
                end
            end
            IDLE: begin
                pulse_next_s   = 1'b0;
                counter_next_s = 8'd0;
                if (start_rise_s) begin
                    next_state_s = DELAY;
                end else begin
                    next_state_s = IDLE;
                end
            end
            DELAY: begin
                // Start edges seen here are dropped, not queued.
                if (counter == START_LAST) begin
                    next_state_s   = PULSE;
                    counter_next_s = 8'd0;
                    pulse_next_s   = 1'b1;
                end else begin
                    counter_next_s = counter + 8'd1;
                end
            end
            PULSE: begin
                // Start edges seen here are dropped, not queued.
                if (counter == WIDTH_LAST) begin
                    next_state_s   = IDLE;
                    counter_next_s = 8'd0;
                    pulse_next_s   = 1'b0;
                end else begin
                    counter_next_s = counter + 8'd1;
                end
            end
            default: begin
                next_state_s   = WAIT_READY;
                counter_next_s = 8'd0;
                pulse_next_s   = 1'b0;
                ready_next_s   = 1'b0;
            end
        endcase
    end

    // State, counter, outputs and start history; reset aborts any pulse at once.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= WAIT_READY;
            counter   <= 8'd0;
            pulse_r   <= 1'b0;
            pulse_s_r <= 1'b0;
            ready_r   <= 1'b0;
            start_d_r <= 1'b0;
        end else begin
            state_r   <= next_state_s;
            counter   <= counter_next_s;
            pulse_r   <= pulse_next_s;
            pulse_s_r <= pulse_r;
            ready_r   <= ready_next_s;
            start_d_r <= start;
        end
    end

`ifdef PULSE_GENERATOR_DUPLICATE_EN
    // Kept as its own flop so a fault in one copy can be detected against the other.
    (* keep = "true" *) logic pulse_dup_r;

    // Redundant copy of pulse_out fed from the same next-value logic.
    always_ff @(posedge clk) begin
        if (reset) begin
            pulse_dup_r <= 1'b0;
        end else begin
            pulse_dup_r <= pulse_next_s;
        end
    end

    assign pulse_out_duplicate = pulse_dup_r;
`else
    assign pulse_out_duplicate = 1'b0;
`endif

    assign pulse_out                         = pulse_r;
    assign pulse_out_s                       = pulse_s_r;
    assign pulse_generator_ready_after_reset = ready_r;

    pulse_generator_checker u_checker (
        .clk                 (clk),
        .reset               (reset),
        .pulse_out           (pulse_r),
        .pulse_out_s         (pulse_s_r),
        .pulse_out_duplicate (pulse_out_duplicate),
        .ready               (ready_r)
    );

endmodule

// File: tb/tb_pulse_generator.sv
// tb_pulse_generator: directed scenarios followed by random start/reset traffic,
// every cycle checked against a timeline model of when ready and pulses occur.
module tb_pulse_generator;

    localparam int RD = 8;
    localparam int SD = 4;
    localparam int PW = 6;

    logic clk;
    logic reset;
    logic start;
    logic pulse_out;
    logic pulse_out_s;
    logic pulse_out_duplicate;
    logic ready;

    int n_cmp;
    int n_err;

    // Reference timeline: edge counter plus the edges at which things happen.
    int   edge_n;
    int   rst_edge;
    int   pulse_on;
    int   pulse_end;
    logic prev_st;
    logic exp_pulse;
    logic exp_pulse_s;
    logic exp_ready;
    logic exp_dup;
    logic rise;

    pulse_generator #(
        .RESET_DELAY (RD),
        .START_DELAY (SD),
        .PULSE_WIDTH (PW)
    ) dut (
        .clk                               (clk),
        .reset                             (reset),
        .start                             (start),
        .pulse_out                         (pulse_out),
        .pulse_out_s                       (pulse_out_s),
        .pulse_out_duplicate               (pulse_out_duplicate),
        .pulse_generator_ready_after_reset (ready)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_bit(input string tag, input logic observed, input logic expected);
        n_cmp++;
        if (observed !== expected) begin
            n_err++;
            $display("FAIL %s at edge %0d: got %b expected %b", tag, edge_n, observed, expected);
        end
    endtask

    // Apply one cycle of inputs, advance the model over the edge, check all outputs.
    task automatic drive_cycle(input logic r, input logic s);
        @(negedge clk);
        reset = r;
        start = s;
        @(posedge clk);
        edge_n++;
        if (r) begin
            rst_edge    = edge_n;
            pulse_on    = -1000;
            pulse_end   = -1000;
            prev_st     = 1'b0;
            exp_pulse   = 1'b0;
            exp_pulse_s = 1'b0;
            exp_ready   = 1'b0;
        end else begin
            rise    = s && !prev_st;
            prev_st = s;
            // Accepted only when ready was already up and no pulse is in flight.
            if (rise && (edge_n - 1 >= rst_edge + RD) && (edge_n > pulse_end)) begin
                pulse_on  = edge_n + SD;
                pulse_end = edge_n + SD + PW;
            end
            exp_pulse_s = exp_pulse;
            exp_pulse   = (edge_n >= pulse_on) && (edge_n < pulse_end);
            exp_ready   = (edge_n >= rst_edge + RD);
        end
`ifdef PULSE_GENERATOR_DUPLICATE_EN
        exp_dup = exp_pulse;
`else
        exp_dup = 1'b0;
`endif
        #1;
        check_bit("ready", ready, exp_ready);
        check_bit("pulse_out", pulse_out, exp_pulse);
        check_bit("pulse_out_s", pulse_out_s, exp_pulse_s);
        check_bit("pulse_out_duplicate", pulse_out_duplicate, exp_dup);
    endtask

    task automatic run(input logic r, input logic s, input int cycles);
        for (int k = 0; k < cycles; k++) begin
            drive_cycle(r, s);
        end
    endtask

    initial begin
        logic st_v;
        int   rst_left;
        reset       = 1'b1;
        start       = 1'b0;
        n_cmp       = 0;
        n_err       = 0;
        edge_n      = 0;
        rst_edge    = 0;
        pulse_on    = -1000;
        pulse_end   = -1000;
        prev_st     = 1'b0;
        exp_pulse   = 1'b0;
        exp_pulse_s = 1'b0;
        exp_ready   = 1'b0;
        exp_dup     = 1'b0;
        rise        = 1'b0;

        // Power-up reset for 10 cycles, then wait for ready.
        run(1'b1, 1'b0, 10);
        run(1'b0, 1'b0, 12);

        // Basic two-cycle start request.
        run(1'b0, 1'b1, 2);
        run(1'b0, 1'b0, 15);

        // Extra start edges during DELAY and PULSE must be ignored.
        run(1'b0, 1'b1, 1);
        run(1'b0, 1'b0, 1);
        run(1'b0, 1'b1, 1);
        run(1'b0, 1'b0, 3);
        run(1'b0, 1'b1, 2);
        run(1'b0, 1'b0, 15);

        // Back-to-back: new edge in the first IDLE cycle after the pulse.
        run(1'b0, 1'b1, 1);
        run(1'b0, 1'b0, 10);
        run(1'b0, 1'b1, 1);
        run(1'b0, 1'b0, 15);

        // Reset two cycles into PULSE, then recovery and a normal pulse.
        run(1'b0, 1'b1, 1);
        run(1'b0, 1'b0, 5);
        run(1'b1, 1'b0, 3);
        run(1'b0, 1'b0, 12);
        run(1'b0, 1'b1, 1);
        run(1'b0, 1'b0, 15);

        // Start held high across reset release is not a request.
        run(1'b0, 1'b1, 2);
        run(1'b1, 1'b1, 3);
        run(1'b0, 1'b1, 15);
        run(1'b0, 1'b0, 2);
        run(1'b0, 1'b1, 2);
        run(1'b0, 1'b0, 15);

        // Random start toggling with occasional short resets.
        st_v     = 1'b0;
        rst_left = 0;
        for (int i = 0; i < 3000; i++) begin
            if (rst_left == 0 && $urandom_range(0, 199) == 0) begin
                rst_left = $urandom_range(1, 4);
            end
            if ($urandom_range(0, 3) == 0) begin
                st_v = ~st_v;
            end
            if (rst_left > 0) begin
                drive_cycle(1'b1, st_v);
                rst_left--;
            end else begin
                drive_cycle(1'b0, st_v);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
